// File: rtl/cla_nibble_sequencer_if.sv
// Handshake/bus bundle for cla_nibble_sequencer: request side (start/operands)
// and response side (busy/done/result).
interface cla_nibble_sequencer_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (output start, a, b, cin, input  busy, done, sum, cout);
  modport slave  (input  start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle W-bit adder: streams one nibble per cycle, LSB first, through a
// single 4-bit carry-lookahead adder, rippling the carry through a register.

module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

module cla_nibble_sequencer #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  cla_nibble_sequencer_if.slave  bus
);
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                    state_q, state_n;
  logic [NIBBLES-1:0][3:0]   a_q, a_n;
  logic [NIBBLES-1:0][3:0]   b_q, b_n;
  logic [NIBBLES-1:0][3:0]   sum_q, sum_n;
  logic [IDX_W-1:0]          idx_q, idx_n;
  logic                      carry_q, carry_n;
  logic                      cout_q, cout_n;

  logic [3:0]                nib_a, nib_b, cla_sum;
  logic                      cla_cout;

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a = a_q[i];
        nib_b = b_q[i];
      end
    end
  end

  cla u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // Next-state and datapath update.
  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    sum_n   = sum_q;
    idx_n   = idx_q;
    carry_n = carry_q;
    cout_n  = cout_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_n     = bus.a;
          b_n     = bus.b;
          carry_n = bus.cin;
          idx_n   = '0;
          sum_n   = '0;
          cout_n  = 1'b0;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) sum_n[i] = cla_sum;
        end
        carry_n = cla_cout;
        if (idx_q == IDX_W'(NIBBLES - 1)) begin
          cout_n  = cla_cout;
          state_n = DONE;
        end else begin
          idx_n = idx_q + IDX_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      sum_q   <= sum_n;
      idx_q   <= idx_n;
      carry_q <= carry_n;
      cout_q  <= cout_n;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule
